pdm_modulator: RTL

PDM_MODULATOR -- requirements
Module: pdm_modulator

---
 rtl/pdm_modulator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta PDM modulator with a one-deep PCM holding buffer.
// Each PCM sample is played for OSR bit periods of CLK_DIV clocks each.
module pdm_modulator #(
    parameter int PCM_W   = 16,
    parameter int ACC_W   = 24,
    parameter int CLK_DIV = 23,
    parameter int OSR     = 64
) (
    input  logic             Clk,
    input  logic             reset_rtl_0,
    input  logic             enable,
    input  logic [PCM_W-1:0] pcm_in,
    input  logic             pcm_valid,
    output logic             pcm_ready,
    output logic             pdm_out,
    output logic             pdm_tick,
    output logic             underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int SUM_W = ACC_W + 2;

    localparam logic signed [SUM_W-1:0] FB_POS =
        SUM_W'((longint'(1) <<< (PCM_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] FB_NEG =
        SUM_W'(-(longint'(1) <<< (PCM_W - 1)));
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        SUM_W'((longint'(1) <<< (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        SUM_W'(-(longint'(1) <<< (ACC_W - 1)));

    logic [DIV_W-1:0]        r_div;
    logic [BIT_W-1:0]        r_bit;
    logic [PCM_W-1:0]        r_cur;
    logic [PCM_W-1:0]        r_nxt;
    logic                    r_nxt_full;
    logic signed [ACC_W-1:0] r_i1;
    logic signed [ACC_W-1:0] r_i2;
    logic                    r_q;

    logic                    w_tick;
    logic                    w_last;
    logic                    w_bound;
    logic                    w_xfer;
    logic signed [SUM_W-1:0] w_x;
    logic signed [SUM_W-1:0] w_fb;
    logic signed [SUM_W-1:0] w_s1;
    logic signed [SUM_W-1:0] w_s2;
    logic signed [ACC_W-1:0] w_i1;
    logic signed [ACC_W-1:0] w_i2;
    logic                    w_q;

    function automatic logic signed [ACC_W-1:0] sat(
        input logic signed [SUM_W-1:0] v
    );
        logic signed [SUM_W-1:0] r;
        r = v;
        if (v > SAT_MAX) r = SAT_MAX;
        if (v < SAT_MIN) r = SAT_MIN;
        return r[ACC_W-1:0];
    endfunction

    assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1)) && !reset_rtl_0;
    assign w_last    = (r_bit == BIT_W'(OSR - 1));
    assign w_bound   = w_tick && enable && w_last;
    assign pcm_ready = enable && !r_nxt_full && !reset_rtl_0;
    assign w_xfer    = pcm_valid && pcm_ready;

    assign pdm_tick  = w_tick;
    assign pdm_out   = r_q;
    assign underrun  = w_bound && !r_nxt_full && !w_xfer;

    // Feedback uses the currently emitted bit; sums carry two guard bits
    always_comb begin
        w_x  = {{(SUM_W-PCM_W){r_cur[PCM_W-1]}}, r_cur};
        w_fb = r_q ? FB_POS : FB_NEG;
        w_s1 = {{2{r_i1[ACC_W-1]}}, r_i1} + w_x - w_fb;
        w_i1 = sat(w_s1);
        w_s2 = {{2{r_i2[ACC_W-1]}}, r_i2}
             + {{2{w_i1[ACC_W-1]}}, w_i1} - w_fb;
        w_i2 = sat(w_s2);
        w_q  = !w_i2[ACC_W-1];
    end

    always_ff @(posedge Clk) begin
        if (reset_rtl_0) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_cur      <= '0;
            r_nxt      <= '0;
            r_nxt_full <= 1'b0;
            r_i1       <= '0;
            r_i2       <= '0;
            r_q        <= 1'b0;
        end else begin
            if (w_tick) r_div <= '0;
            else        r_div <= r_div + DIV_W'(1);

            if (!enable) begin
                r_bit      <= '0;
                r_i1       <= '0;
                r_i2       <= '0;
                r_nxt_full <= 1'b0;
                if (w_tick) r_q <= ~r_q;
            end else begin
                if (w_tick) begin
                    if (w_last) r_bit <= '0;
                    else        r_bit <= r_bit + BIT_W'(1);
                    r_i1 <= w_i1;
                    r_i2 <= w_i2;
                    r_q  <= w_q;
                end
                if (w_xfer) begin
                    r_nxt      <= pcm_in;
                    r_nxt_full <= 1'b1;
                end else if (w_bound && r_nxt_full) begin
                    r_cur      <= r_nxt;
                    r_nxt_full <= 1'b0;
                end
            end
        end
    end

endmodule
